stream_result_checker: RTL and testbench

- Synthesizable response checker for PE datapaths; the counterpart to the stimulus side.
- Takes the DUT output stream and an expected-result stream on two valid/ready channels and pairs them in order.
- Compares each pair, counts vectors and errors, captures the first mismatch, and compacts DUT outputs into a MISR signature.
- Sits after the DUT in on-chip self-test wrappers and in file-driven benches, so pass/fail is decided by RTL instead of bench code.

---
 rtl/stream_result_checker.sv | 113 +++++++++++
 tb/tb_stream_result_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_result_checker.sv
// Response checker: pairs DUT and expected streams in order, counts vectors
// and errors, captures the first mismatch, and compacts DUT words into a MISR.
module stream_result_checker #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       CNT_W     = 32,
  parameter logic [DATA_W-1:0] MISR_POLY = DATA_W'(16'h1021),
  parameter logic [DATA_W-1:0] MISR_SEED = DATA_W'(16'hFFFF)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_vec_i,
  input  logic              dut_valid_i,
  input  logic [DATA_W-1:0] dut_data_i,
  output logic              dut_ready_o,
  input  logic              exp_valid_i,
  input  logic [DATA_W-1:0] exp_data_i,
  output logic              exp_ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [CNT_W-1:0]  vec_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [CNT_W-1:0]  first_err_idx_o,
  output logic [DATA_W-1:0] first_err_dut_o,
  output logic [DATA_W-1:0] first_err_exp_o,
  output logic [DATA_W-1:0] signature_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   target;
  logic               xfer;
  logic               mismatch;
  logic [CNT_W-1:0]   vec_inc;
  logic [CNT_W-1:0]   err_inc;
  logic [DATA_W-1:0]  misr_next;

  // Joint handshake: a pair moves only when both sides are valid in RUN
  assign xfer        = (state == RUN) & dut_valid_i & exp_valid_i;
  assign dut_ready_o = xfer;
  assign exp_ready_o = xfer;

  assign busy_o = (state == RUN);
  assign pass_o = done_o & (err_cnt_o == '0);

  // Saturating increments, compare result and next MISR value
  always_comb begin
    mismatch  = (dut_data_i != exp_data_i);
    vec_inc   = (vec_cnt_o == '1) ? vec_cnt_o : vec_cnt_o + CNT_W'(1);
    err_inc   = (err_cnt_o == '1) ? err_cnt_o : err_cnt_o + CNT_W'(1);
    misr_next = {signature_o[DATA_W-2:0], 1'b0}
              ^ (signature_o[DATA_W-1] ? MISR_POLY : '0)
              ^ dut_data_i;
  end

  // Run control, counters, first-mismatch capture and signature
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state           <= IDLE;
      target          <= '0;
      done_o          <= 1'b0;
      vec_cnt_o       <= '0;
      err_cnt_o       <= '0;
      first_err_idx_o <= '0;
      first_err_dut_o <= '0;
      first_err_exp_o <= '0;
      signature_o     <= MISR_SEED;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start_i) begin
            target          <= num_vec_i;
            vec_cnt_o       <= '0;
            err_cnt_o       <= '0;
            first_err_idx_o <= '0;
            first_err_dut_o <= '0;
            first_err_exp_o <= '0;
            signature_o     <= MISR_SEED;
            // An empty run completes immediately with a clean result
            done_o          <= (num_vec_i == '0);
            state           <= (num_vec_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            vec_cnt_o   <= vec_inc;
            signature_o <= misr_next;
            if (mismatch) begin
              err_cnt_o <= err_inc;
              if (err_cnt_o == '0) begin
                first_err_idx_o <= vec_cnt_o;
                first_err_dut_o <= dut_data_i;
                first_err_exp_o <= exp_data_i;
              end
            end
            if (vec_inc == target) begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_result_checker.sv
// Directed self-checking bench for stream_result_checker.
module tb_stream_result_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] num_vec;
  logic        dut_valid;
  logic [15:0] dut_data;
  logic        dut_ready;
  logic        exp_valid;
  logic [15:0] exp_data;
  logic        exp_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] vec_cnt;
  logic [31:0] err_cnt;
  logic [31:0] first_err_idx;
  logic [15:0] first_err_dut;
  logic [15:0] first_err_exp;
  logic [15:0] signature;

  int n_cmp = 0;
  int n_err = 0;

  stream_result_checker dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .num_vec_i       (num_vec),
    .dut_valid_i     (dut_valid),
    .dut_data_i      (dut_data),
    .dut_ready_o     (dut_ready),
    .exp_valid_i     (exp_valid),
    .exp_data_i      (exp_data),
    .exp_ready_o     (exp_ready),
    .busy_o          (busy),
    .done_o          (done),
    .pass_o          (pass),
    .vec_cnt_o       (vec_cnt),
    .err_cnt_o       (err_cnt),
    .first_err_idx_o (first_err_idx),
    .first_err_dut_o (first_err_dut),
    .first_err_exp_o (first_err_exp),
    .signature_o     (signature)
  );

  always #5 clk = ~clk;

  // Reference MISR step: shift left, fold in polynomial on carry-out, xor data
  function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
  endfunction

  // Pulse start for one edge; returns at edge+1 with start low
  task automatic do_start(input logic [31:0] n);
    @(posedge clk); #1;
    start = 1'b1; num_vec = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dut_valid = 1'b1; exp_valid = 1'b1;
    dut_data = 16'h1111; exp_data = 16'h1111;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b want 0", done); end
    n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL reset_pass got %0b want 0", pass); end
    n_cmp++; if (vec_cnt !== 32'd0 || err_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt got vec=%0d err=%0d want 0/0", vec_cnt, err_cnt); end
    n_cmp++; if (first_err_idx !== 32'd0 || first_err_dut !== 16'd0 || first_err_exp !== 16'd0) begin
      n_err++; $display("FAIL reset_first got %h/%h/%h want 0/0/0", first_err_idx, first_err_dut, first_err_exp); end
    n_cmp++; if (signature !== 16'hFFFF) begin n_err++; $display("FAIL reset_sig got %h want ffff", signature); end
    n_cmp++; if (dut_ready !== 1'b0 || exp_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %0b%0b want 00", dut_ready, exp_ready); end
    rst_n = 1'b1; dut_valid = 1'b0; exp_valid = 1'b0;
  endtask

  task automatic test_matched();
    logic [15:0] esig;
    esig = 16'hFFFF;
    do_start(32'd4);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL match_busy got %0b want 1", busy); end
    for (int i = 0; i < 4; i++) begin
      dut_valid = 1'b1; exp_valid = 1'b1;
      dut_data = 16'(i + 1); exp_data = 16'(i + 1);
      #1;
      n_cmp++; if (dut_ready !== 1'b1 || exp_ready !== 1'b1) begin n_err++; $display("FAIL match_ready[%0d] got %0b%0b want 11", i, dut_ready, exp_ready); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL match_early_done[%0d] got %0b want 0", i, done); end
      esig = misr(esig, 16'(i + 1));
      @(posedge clk); #1;
    end
    dut_valid = 1'b0; exp_valid = 1'b0;
    n_cmp++; if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL match_done got d=%0b p=%0b b=%0b want 1/1/0", done, pass, busy); end
    n_cmp++; if (vec_cnt !== 32'd4 || err_cnt !== 32'd0) begin n_err++; $display("FAIL match_cnt got vec=%0d err=%0d want 4/0", vec_cnt, err_cnt); end
    n_cmp++; if (signature !== esig) begin n_err++; $display("FAIL match_sig got %h want %h", signature, esig); end
  endtask

  task automatic test_mismatch();
    logic [15:0] dv [5];
    logic [15:0] ev [5];
    logic [15:0] esig;
    dv = '{16'h0010, 16'h00AA, 16'h0020, 16'h1234, 16'h0030};
    ev = '{16'h0010, 16'h00AB, 16'h0020, 16'h4321, 16'h0030};
    esig = 16'hFFFF;
    do_start(32'd5);
    n_cmp++; if (err_cnt !== 32'd0 || vec_cnt !== 32'd0) begin n_err++; $display("FAIL mm_cleared got vec=%0d err=%0d want 0/0", vec_cnt, err_cnt); end
    for (int i = 0; i < 5; i++) begin
      dut_valid = 1'b1; exp_valid = 1'b1;
      dut_data = dv[i]; exp_data = ev[i];
      esig = misr(esig, dv[i]);
      @(posedge clk); #1;
    end
    dut_valid = 1'b0; exp_valid = 1'b0;
    n_cmp++; if (err_cnt !== 32'd2 || vec_cnt !== 32'd5) begin n_err++; $display("FAIL mm_cnt got vec=%0d err=%0d want 5/2", vec_cnt, err_cnt); end
    n_cmp++; if (first_err_idx !== 32'd1) begin n_err++; $display("FAIL mm_idx got %0d want 1", first_err_idx); end
    n_cmp++; if (first_err_dut !== 16'h00AA || first_err_exp !== 16'h00AB) begin n_err++; $display("FAIL mm_words got %h/%h want 00aa/00ab", first_err_dut, first_err_exp); end
    n_cmp++; if (done !== 1'b1 || pass !== 1'b0) begin n_err++; $display("FAIL mm_pass got d=%0b p=%0b want 1/0", done, pass); end
    n_cmp++; if (signature !== esig) begin n_err++; $display("FAIL mm_sig got %h want %h", signature, esig); end
  endtask

  task automatic test_stall();
    int xfers;
    logic want;
    xfers = 0;
    do_start(32'd2);
    dut_valid = 1'b1; dut_data = 16'h5A5A;
    for (int c = 0; c < 8; c++) begin
      exp_valid = (c == 3 || c == 6);
      exp_data  = (c == 3) ? 16'h5A5A : 16'hC3C3;
      #1;
      want = (c == 3 || c == 6);
      n_cmp++; if (dut_ready !== want || exp_ready !== want) begin n_err++; $display("FAIL stall_ready[%0d] got %0b%0b want %0b", c, dut_ready, exp_ready, want); end
      if (dut_ready === 1'b1) xfers++;
      @(posedge clk); #1;
      // Present a new DUT word only once the old one has been consumed
      if (c == 3) dut_data = 16'hC3C3;
    end
    dut_valid = 1'b0; exp_valid = 1'b0;
    n_cmp++; if (xfers != 2) begin n_err++; $display("FAIL stall_xfers got %0d want 2", xfers); end
    n_cmp++; if (vec_cnt !== 32'd2 || err_cnt !== 32'd0 || pass !== 1'b1) begin n_err++; $display("FAIL stall_result got vec=%0d err=%0d pass=%0b want 2/0/1", vec_cnt, err_cnt, pass); end
    n_cmp++; if (signature !== misr(misr(16'hFFFF, 16'h5A5A), 16'hC3C3)) begin n_err++; $display("FAIL stall_sig got %h", signature); end
  endtask

  task automatic test_zero_len();
    do_start(32'd0);
    dut_valid = 1'b1; exp_valid = 1'b1; dut_data = 16'h0001; exp_data = 16'h0002;
    #1;
    n_cmp++; if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL zero_done got d=%0b p=%0b b=%0b want 1/1/0", done, pass, busy); end
    n_cmp++; if (vec_cnt !== 32'd0 || signature !== 16'hFFFF) begin n_err++; $display("FAIL zero_clear got vec=%0d sig=%h want 0/ffff", vec_cnt, signature); end
    n_cmp++; if (dut_ready !== 1'b0 || exp_ready !== 1'b0) begin n_err++; $display("FAIL zero_ready got %0b%0b want 00", dut_ready, exp_ready); end
    @(posedge clk); #1;
    dut_valid = 1'b0; exp_valid = 1'b0;
    n_cmp++; if (vec_cnt !== 32'd0 || done !== 1'b1) begin n_err++; $display("FAIL zero_hold got vec=%0d done=%0b want 0/1", vec_cnt, done); end
  endtask

  task automatic test_start_in_run();
    do_start(32'd3);
    for (int i = 0; i < 3; i++) begin
      dut_valid = 1'b1; exp_valid = 1'b1;
      dut_data = 16'h0100 + 16'(i); exp_data = 16'h0100 + 16'(i);
      if (i == 1) begin start = 1'b1; num_vec = 32'd9; end
      @(posedge clk); #1;
      start = 1'b0;
      if (i == 1) begin
        n_cmp++; if (vec_cnt !== 32'd2 || busy !== 1'b1) begin n_err++; $display("FAIL run_start_ignored got vec=%0d busy=%0b want 2/1", vec_cnt, busy); end
      end
    end
    dut_valid = 1'b0; exp_valid = 1'b0;
    n_cmp++; if (done !== 1'b1 || vec_cnt !== 32'd3 || pass !== 1'b1) begin n_err++; $display("FAIL run_start_end got d=%0b vec=%0d p=%0b want 1/3/1", done, vec_cnt, pass); end
  endtask

  task automatic test_reset_mid_run();
    do_start(32'd6);
    for (int i = 0; i < 2; i++) begin
      dut_valid = 1'b1; exp_valid = 1'b1;
      dut_data = 16'h7000 + 16'(i); exp_data = 16'h7001;
      @(posedge clk); #1;
    end
    n_cmp++; if (vec_cnt !== 32'd2 || err_cnt !== 32'd1) begin n_err++; $display("FAIL mid_pre got vec=%0d err=%0d want 2/1", vec_cnt, err_cnt); end
    // Reset and start together: reset must win
    rst_n = 1'b0; start = 1'b1; num_vec = 32'd2;
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || vec_cnt !== 32'd0 || err_cnt !== 32'd0) begin
      n_err++; $display("FAIL mid_reset got b=%0b d=%0b vec=%0d err=%0d want 0/0/0/0", busy, done, vec_cnt, err_cnt); end
    n_cmp++; if (signature !== 16'hFFFF || first_err_idx !== 32'd0) begin n_err++; $display("FAIL mid_reset_sig got %h idx=%0d want ffff/0", signature, first_err_idx); end
    n_cmp++; if (dut_ready !== 1'b0 || exp_ready !== 1'b0) begin n_err++; $display("FAIL mid_reset_ready got %0b%0b want 00", dut_ready, exp_ready); end
    dut_valid = 1'b0; exp_valid = 1'b0;
    do_start(32'd2);
    for (int i = 0; i < 2; i++) begin
      dut_valid = 1'b1; exp_valid = 1'b1;
      dut_data = 16'hBEEF; exp_data = 16'hBEEF;
      @(posedge clk); #1;
    end
    dut_valid = 1'b0; exp_valid = 1'b0;
    n_cmp++; if (done !== 1'b1 || pass !== 1'b1 || vec_cnt !== 32'd2) begin n_err++; $display("FAIL mid_rerun got d=%0b p=%0b vec=%0d want 1/1/2", done, pass, vec_cnt); end
    n_cmp++; if (signature !== misr(misr(16'hFFFF, 16'hBEEF), 16'hBEEF)) begin n_err++; $display("FAIL mid_rerun_sig got %h", signature); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_vec = '0;
    dut_valid = 1'b0; dut_data = '0; exp_valid = 1'b0; exp_data = '0;
    test_reset();
    test_matched();
    test_mismatch();
    test_stall();
    test_zero_len();
    test_start_in_run();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
